serial_to_parallel_rx: RTL and testbench

//  Receive-side deserializer ahead of the 1:4 byte demux. Shifts in one serial bit per clk_32f.

---
 rtl/serial_to_parallel_rx_if.sv | 13 +
 rtl/serial_to_parallel_rx.sv | 69 ++++++
 tb/tb_serial_to_parallel_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_rx_if.sv
// serial_to_parallel_rx_if: serial bit input and byte output bundle for the rx deserializer
//   data_in   : serial data, MSB of each byte first (master -> slave)
//   data_out  : last accepted byte (slave -> master)
//   valid_out : data_out holds a non-idle byte received after lock (slave -> master)
//   active    : lock achieved, sticky until reset (slave -> master)
interface serial_to_parallel_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  modport master (output data_in, input data_out, valid_out, active);
  modport slave (input data_in, output data_out, valid_out, active);
endinterface

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: MSB-first byte deserializer that locks on IDLE_CHAR training
//   clk_32f : serial bit clock, all logic on posedge
//   reset   : synchronous, active-low
//   rx      : serial_to_parallel_rx_if.slave (data_in in; data_out, valid_out, active out)
//   Optional build macro SP_COMMA_REALIGN_EN: while searching, any cycle whose last
//   eight bits equal IDLE_CHAR is taken as a byte boundary, realigning the framing.
module serial_to_parallel_rx #(
  parameter logic [7:0] IDLE_CHAR    = 8'hBC,
  parameter int         BC_THRESHOLD = 4
) (
  input  logic                     clk_32f,
  input  logic                     reset,
  serial_to_parallel_rx_if.slave   rx
);
  typedef enum logic {SEARCH, ACTIVE} state_t;
  state_t      state_q, state_d;
  logic [6:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  bc_cnt_q, bc_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [7:0]  byte_w;
  logic        is_idle, realign, decide;
  always_comb begin
    byte_w = {shift_q, rx.data_in};
    is_idle = byte_w == IDLE_CHAR;
`ifdef SP_COMMA_REALIGN_EN
    realign = state_q == SEARCH && is_idle;
`else
    realign = 1'b0;
`endif
    decide = bit_cnt_q == 3'd7 || realign;
    shift_d = byte_w[6:0];
    bit_cnt_d = realign ? 3'd0 : bit_cnt_q + 3'd1;
    bc_cnt_d = bc_cnt_q;
    state_d = state_q;
    data_d = data_q;
    valid_d = valid_q;
    if (decide && state_q == SEARCH) begin
      // saturate at the threshold so a long training run never wraps the count
      bc_cnt_d = !is_idle ? 4'd0 : bc_cnt_q == 4'(BC_THRESHOLD) ? bc_cnt_q : bc_cnt_q + 4'd1;
      state_d = is_idle && bc_cnt_q + 4'd1 >= 4'(BC_THRESHOLD) ? ACTIVE : SEARCH;
    end
    if (decide && state_q == ACTIVE) begin
      valid_d = !is_idle;
      data_d = is_idle ? data_q : byte_w;
    end
  end
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q <= SEARCH;
      shift_q <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q <= bc_cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign rx.data_out = data_q;
  assign rx.valid_out = valid_q;
  assign rx.active = state_q == ACTIVE;
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: randomized and directed checks against a byte-level reference model
module tb_serial_to_parallel_rx;
  localparam logic [7:0] BC = 8'hBC;
  localparam int TH = 4;
  logic clk_32f = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic m_active, m_valid;
  logic [7:0] m_data;
  int m_bc;
  serial_to_parallel_rx_if rx ();
  serial_to_parallel_rx #(.IDLE_CHAR(BC), .BC_THRESHOLD(TH)) dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .rx(rx.slave)
  );
  always #5 clk_32f = ~clk_32f;
  task automatic tick(input logic b);
    rx.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask
  task automatic model_clear;
    m_active = 1'b0;
    m_valid = 1'b0;
    m_data = 8'h00;
    m_bc = 0;
  endtask
  // byte-level view: count consecutive idles until the threshold, then forward non-idles
  task automatic model_byte(input logic [7:0] b);
    if (!m_active) begin
      m_bc = (b == BC) ? m_bc + 1 : 0;
      if (m_bc >= TH) m_active = 1'b1;
    end else begin
      m_valid = (b != BC);
      if (b != BC) m_data = b;
    end
  endtask
  task automatic do_reset;
    reset = 1'b0;
    tick(1'b1);
    reset = 1'b1;
    model_clear();
  endtask
  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(i[0]);
      n_cmp++;
      if ({rx.active, rx.valid_out, rx.data_out} !== 10'h000) begin
        n_err++;
        $display("FAIL reset cycle%0d: got %h want 000", i, {rx.active, rx.valid_out, rx.data_out});
      end
    end
    reset = 1'b1;
    model_clear();
  endtask
  task automatic test_stream(input string name, input logic [7:0] q[$]);
    foreach (q[k]) for (int i = 7; i >= 0; i--) begin
      tick(q[k][i]);
      if (i == 0) model_byte(q[k]);
      n_cmp++;
      if ({rx.active, rx.valid_out, rx.data_out} !== {m_active, m_valid, m_data}) begin
        n_err++;
        $display("FAIL %s byte%0d bit%0d: got %h want %h", name, k, 7 - i,
                 {rx.active, rx.valid_out, rx.data_out}, {m_active, m_valid, m_data});
      end
    end
  endtask
  task automatic test_lock;
    do_reset();
    test_stream("lock", '{BC, BC, BC, BC});
  endtask
  task automatic test_broken_training;
    do_reset();
    test_stream("broken", '{BC, BC, BC, 8'h55, BC, BC, BC, BC});
  endtask
  task automatic test_data;
    do_reset();
    test_stream("data", '{BC, BC, BC, BC, 8'hA7, 8'h3C, BC});
  endtask
  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      q.push_back(b == BC ? 8'h01 : b);
    end
    test_stream("b2b", q);
  endtask
  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] b;
    do_reset();
    q = '{BC, BC, BC, BC};
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      q.push_back($urandom_range(3) == 0 ? BC : b);
    end
    test_stream("random", q);
  endtask
  task automatic test_mid_reset;
    logic [7:0] a7;
    a7 = 8'hA7;
    do_reset();
    test_stream("premid", '{BC, BC, BC, BC, 8'h5A});
    for (int i = 7; i >= 5; i--) tick(a7[i]);
    reset = 1'b0;
    tick(a7[4]);
    n_cmp++;
    if ({rx.active, rx.valid_out, rx.data_out} !== 10'h000) begin
      n_err++;
      $display("FAIL midreset: got %h want 000", {rx.active, rx.valid_out, rx.data_out});
    end
    reset = 1'b1;
    model_clear();
    test_stream("relock", '{BC, BC, BC, 8'hA7, BC, BC, BC, BC, 8'hA7});
  endtask
  task automatic test_realign;
    logic exp_act;
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0);
    for (int k = 1; k <= 5; k++) begin
      for (int i = 7; i >= 0; i--) tick(BC[i]);
`ifdef SP_COMMA_REALIGN_EN
      exp_act = (k >= 4);
`else
      exp_act = 1'b0;
`endif
      n_cmp++;
      if ({rx.active, rx.valid_out, rx.data_out} !== {exp_act, 9'h000}) begin
        n_err++;
        $display("FAIL realign byte%0d: got %h want %h", k, {rx.active, rx.valid_out, rx.data_out},
                 {exp_act, 9'h000});
      end
    end
  endtask
  initial begin
    rx.data_in = 1'b0;
    test_reset();
    test_lock();
    test_broken_training();
    test_data();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_realign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
